// File: rtl/led_sequencer.sv
// LED pattern sequencer: rotate-right, rotate-left, bounce and binary count,
// stepped by a speed-scaled prescaler or by single-step requests while paused.
module led_sequencer #(
  parameter int N_LED    = 4,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  input  logic             step,
  output logic [N_LED-1:0] led,
  output logic             tick,
  output logic             dir
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int PW = $clog2(N_LED);

  localparam logic [1:0] MODE_ROT_R  = 2'd0;
  localparam logic [1:0] MODE_ROT_L  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  localparam logic [PW-1:0] POS_MAX = PW'(N_LED - 1);

  logic [CW-1:0]    cnt;
  logic [1:0]       mode_q;
  logic [PW-1:0]    pos;
  logic             step_q;

  logic [31:0]      period_m1;
  logic             terminal;
  logic             step_rise;
  logic             advance;
  logic             mode_chg;
  logic [N_LED-1:0] led_init;
  logic [N_LED-1:0] led_nxt;
  logic [PW-1:0]    pos_nxt;
  logic             dir_nxt;

  // Compare with >= so that raising speed mid-count wraps on the next cycle.
  assign period_m1 = (32'(TICK_DIV) >> speed) - 32'd1;
  assign terminal  = en && (32'(cnt) >= period_m1);
  assign step_rise = !en && step && !step_q;
  assign advance   = terminal || step_rise;
  assign mode_chg  = (mode != mode_q);
  assign led_init  = (mode == MODE_COUNT) ? '0 : N_LED'(1);

  always_comb begin
    led_nxt = led;
    pos_nxt = pos;
    dir_nxt = dir;
    case (mode_q)
      MODE_ROT_R: led_nxt = {led[0], led[N_LED-1:1]};
      MODE_ROT_L: led_nxt = {led[N_LED-2:0], led[N_LED-1]};
      MODE_BOUNCE: begin
        if (dir) begin
          if (pos == POS_MAX) begin
            pos_nxt = POS_MAX - PW'(1);
            dir_nxt = 1'b0;
          end else begin
            pos_nxt = pos + PW'(1);
          end
        end else begin
          if (pos == '0) begin
            pos_nxt = PW'(1);
            dir_nxt = 1'b1;
          end else begin
            pos_nxt = pos - PW'(1);
          end
        end
        led_nxt          = '0;
        led_nxt[pos_nxt] = 1'b1;
      end
      default: led_nxt = led + N_LED'(1);
    endcase
  end

  // tick is a one-cycle strobe qualifying a freshly stepped led value; there
  // is no back-pressure, so every accepted advance produces exactly one tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      mode_q <= MODE_ROT_R;
      led    <= N_LED'(1);
      pos    <= '0;
      dir    <= 1'b1;
      tick   <= 1'b0;
      step_q <= 1'b0;
    end else begin
      step_q <= step;
      tick   <= 1'b0;
      if (mode_chg) begin
        // A mode change discards any advance requested in the same cycle.
        mode_q <= mode;
        cnt    <= '0;
        dir    <= 1'b1;
        pos    <= '0;
        led    <= led_init;
      end else begin
        if (en) begin
          cnt <= terminal ? '0 : cnt + CW'(1);
        end
        if (advance) begin
          tick <= 1'b1;
          led  <= led_nxt;
          pos  <= pos_nxt;
          dir  <= dir_nxt;
        end
      end
    end
  end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter N_LED, default 4, number of LED outputs, legal range 2..16.
REQ-002 SHALL have parameter TICK_DIV, default 50_000_000, clock cycles per pattern step at speed 0, legal minimum 8.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  input  1  1 = free-run, 0 = pause (prescaler holds).
REQ-006 SHALL have port mode  input  2  pattern: 0 rotate-right, 1 rotate-left, 2 bounce, 3 binary count.
REQ-007 SHALL have port speed  input  2  step period = TICK_DIV >> speed cycles.
REQ-008 SHALL have port step  input  1  single-step request, honoured only while en=0, rising-edge detected.
REQ-009 SHALL have port led  output  N_LED  registered pattern output.
REQ-010 SHALL have port tick  output  1  registered one-cycle pulse, high in the cycle led first shows a stepped value.
REQ-011 SHALL have port dir  output  1  bounce direction, 1 = toward MSB; 1 in all other modes.

Function
REQ-012 Prescaler cnt, width clog2(TICK_DIV), SHALL count 0..P-1 while en=1, P = TICK_DIV >> speed; hold value while en=0.
REQ-013 Terminal condition SHALL be cnt >= P-1 so a speed increase mid-count wraps on the next cycle; on terminal cnt <= 0 and one advance is generated.
REQ-014 While en=0, a 0->1 transition of step (step=1, previous-cycle step=0) SHALL generate one advance; step SHALL be ignored while en=1.
REQ-015 Mode 0 advance: led <= {led[0], led[N_LED-1:1]}.
REQ-016 Mode 1 advance: led <= {led[N_LED-2:0], led[N_LED-1]}.
REQ-017 Mode 2 uses position pos 0..N_LED-1, led = one-hot(pos); advance with dir=1: pos+1, except at pos=N_LED-1 -> pos=N_LED-2, dir=0; dir=0: pos-1, except at pos=0 -> pos=1, dir=1; sequence period 2*N_LED-2 steps.
REQ-018 Mode 3 advance: led <= led + 1 modulo 2^N_LED (all-ones wraps to zero).
REQ-019 Internal mode_q SHALL register the active mode; when mode != mode_q: mode_q <= mode, cnt <= 0, dir <= 1, pos <= 0, led <= init(mode): 1 for modes 0/1/2, 0 for mode 3; tick stays 0.
REQ-020 Mode change and advance in the same cycle: mode change wins, advance discarded.
REQ-021 tick SHALL be 1 exactly in the cycle after an accepted advance (same edge that updates led), else 0.
REQ-022 Latency: advance generated in cycle k -> new led and tick=1 visible in cycle k+1.

Reset
REQ-023 On rst_n=0 at a clk edge: cnt=0, mode_q=0, led=1 (bit 0 only), pos=0, dir=1, tick=0, step history=0.
REQ-024 Reset SHALL override all other inputs, including mid-step and mid-mode-change.
REQ-025 If mode != 0 when reset releases, REQ-019 SHALL apply on the first post-reset cycle.

Verification (N_LED=4, TICK_DIV=8)
REQ-026 Reset, mode=0, speed=0, en=1 -> led 0001, 1000, 0100, 0010, 0001, one step every 8 cycles, tick high 1 cycle per step.
REQ-027 mode=2, speed=3 -> led one step per cycle: 0001,0010,0100,1000,0100,0010,0001,0010; dir falls at 1000, rises at 0001.
REQ-028 mode=3, speed=3, run 16 steps -> led counts 0000..1111 then 0000; mode change to 3 shows led=0000 with no tick.
REQ-029 en=0, hold step=1 for 5 cycles, then pulse it twice -> exactly 3 advances total; cnt frozen throughout; en=1 with step=1 -> no extra advances.
REQ-030 speed 0 with cnt=5, switch to speed=2 (P=2) -> wrap and advance on next cycle, then one advance every 2 cycles.
REQ-031 Mode change coincident with terminal count, and rst_n=0 mid-bounce at led=0100 -> init pattern loaded with no advance; after reset led=0001, dir=1, tick=0.
